fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the control unit. It owns the program counter and drives the synchronous instruction ROM address. It presents the current instruction's 7-bit opcode and 8-bit literal to the control unit and applies the control unit's `L_PC` jump request with zero bubbles. It also tracks halt, PC wrap-around and a retired-instruction count for debug and verification.

---
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Handshake bundle between the fetch stage, the instruction ROM and the control unit.
// The fetch stage uses the master view; the ROM/control-unit side uses the slave view.
interface fetch_if #(
    parameter int PC_WIDTH = 8
) ();
    logic                stall;
    logic                L_PC;
    logic [PC_WIDTH-1:0] pc_target;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [14:0]         imem_rdata;
    logic [6:0]          opcode;
    logic [7:0]          literal;
    logic                instr_valid;
    logic [PC_WIDTH-1:0] pc;
    logic                halted;
    logic                pc_wrap;
    logic [15:0]         retired;

    modport master (
        input  stall, L_PC, pc_target, imem_rdata,
        output imem_addr, opcode, literal, instr_valid, pc, halted, pc_wrap, retired
    );

    modport slave (
        output stall, L_PC, pc_target, imem_rdata,
        input  imem_addr, opcode, literal, instr_valid, pc, halted, pc_wrap, retired
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses a synchronous ROM, applies
// zero-bubble jumps from the control unit and tracks halt, wrap and retire count.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = {PC_WIDTH{1'b0}},
    parameter logic [6:0]          HALT_OPCODE = 7'h7F
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic                instr_valid_q;
    logic                pc_wrap_q;
    logic [15:0]         retired_q;

    logic [PC_WIDTH-1:0] addr_d;
    logic [6:0]          rd_opcode_s;
    logic                halt_instr_s;
    logic                retire_s;
    logic                seq_s;

    // Next fetch address in priority order, plus retire/halt/sequential decode.
    always_comb begin
        rd_opcode_s  = bus.imem_rdata[14:8];
        halt_instr_s = instr_valid_q && (rd_opcode_s == HALT_OPCODE);
        retire_s     = (state_q == ST_RUN) && instr_valid_q && !bus.stall;
        seq_s        = 1'b0;
        addr_d       = pc_q;
        if (reset) begin
            addr_d = RESET_PC;
        end else if (state_q == ST_HALT) begin
            addr_d = pc_q;
        end else if (bus.stall) begin
            addr_d = pc_q;
        end else if (!instr_valid_q) begin
            // Priming cycle after reset: the ROM already holds RESET_PC, re-read it.
            addr_d = pc_q;
        end else if (halt_instr_s) begin
            addr_d = pc_q;
        end else if (bus.L_PC) begin
            addr_d = bus.pc_target;
        end else begin
            addr_d = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            seq_s  = 1'b1;
        end
    end

    // Architectural state: PC tracks the ROM address, halt FSM, wrap flag, retire count.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            state_q       <= ST_RUN;
            pc_wrap_q     <= 1'b0;
            retired_q     <= 16'h0000;
        end else begin
            pc_q <= addr_d;
            if (retire_s && (retired_q != 16'hFFFF)) begin
                retired_q <= retired_q + 16'h0001;
            end
            if (seq_s && (&pc_q)) begin
                pc_wrap_q <= 1'b1;
            end
            case (state_q)
                ST_RUN: begin
                    if (retire_s && halt_instr_s) begin
                        state_q       <= ST_HALT;
                        instr_valid_q <= 1'b0;
                    end else begin
                        instr_valid_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    instr_valid_q <= 1'b0;
                end
                default: begin
                    state_q       <= ST_RUN;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_addr   = addr_d;
    assign bus.opcode      = instr_valid_q ? rd_opcode_s : 7'h00;
    assign bus.literal     = instr_valid_q ? bus.imem_rdata[7:0] : 8'h00;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.halted      = (state_q == ST_HALT);
    assign bus.pc_wrap     = pc_wrap_q;
    assign bus.retired     = retired_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a ROM model plus an instruction-level reference
// model push expected outputs per cycle; a negedge monitor pops and compares.
module tb_fetch_unit;
    localparam int         PW      = 8;
    localparam logic [6:0] HALT_OP = 7'h7F;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_if #(.PC_WIDTH(PW)) bus ();

    fetch_unit #(
        .PC_WIDTH   (PW),
        .RESET_PC   (8'h00),
        .HALT_OPCODE(7'h7F)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [7:0]  pc;
        logic [7:0]  addr;
        logic        valid;
        logic [6:0]  op;
        logic [7:0]  lit;
        logic        halted;
        logic        wrap;
        logic [15:0] retired;
    } exp_t;

    logic [14:0] mem [256];
    exp_t        sb_q [$];
    int          vectors     = 0;
    int          miscompares = 0;

    // reference model: what is presented this cycle
    logic [7:0]  m_pc;
    logic        m_valid, m_halted, m_wrap;
    logic [15:0] m_retired;
    logic [14:0] cur_word;
    logic        p_reset, p_stall, p_lpc;
    logic [7:0]  p_tgt;
    logic [7:0]  rom_addr;

    function automatic logic [7:0] next_addr(input logic r, input logic s, input logic l,
                                             input logic [7:0] t, output logic seq);
        seq = 1'b0;
        if (r) return 8'h00;
        if (m_halted || s || !m_valid || (cur_word[14:8] == HALT_OP)) return m_pc;
        if (l) return t;
        seq = 1'b1;
        return m_pc + 8'd1;
    endfunction

    task automatic fill_mem(input logic halt_ok);
        logic [6:0] op;
        for (int i = 0; i < 256; i++) begin
            op = 7'($urandom_range(0, 126));
            if (halt_ok && ($urandom_range(0, 31) == 0)) op = HALT_OP;
            mem[i] = {op, 8'($urandom)};
        end
    endtask

    task automatic tick();
        logic       seq;
        logic [7:0] na;
        logic       retire;
        @(posedge clk);
        #1;
        if (p_reset) begin
            m_pc = 8'h00; m_valid = 1'b0; m_halted = 1'b0; m_wrap = 1'b0; m_retired = 16'd0;
        end else begin
            na     = next_addr(1'b0, p_stall, p_lpc, p_tgt, seq);
            retire = !m_halted && m_valid && !p_stall;
            if (seq && (m_pc == 8'hFF)) m_wrap = 1'b1;
            if (retire && (m_retired != 16'hFFFF)) m_retired = m_retired + 16'd1;
            if (retire && (cur_word[14:8] == HALT_OP)) m_halted = 1'b1;
            m_valid = !m_halted;
            m_pc    = na;
        end
        bus.imem_rdata = mem[rom_addr];
        cur_word       = mem[m_pc];
    endtask

    task automatic drive(input logic r, input logic s, input logic l, input logic [7:0] t);
        exp_t e;
        logic seq;
        reset = r; bus.stall = s; bus.L_PC = l; bus.pc_target = t;
        e.addr    = next_addr(r, s, l, t, seq);
        e.pc      = m_pc;
        e.valid   = m_valid;
        e.op      = m_valid ? cur_word[14:8] : 7'h00;
        e.lit     = m_valid ? cur_word[7:0] : 8'h00;
        e.halted  = m_halted;
        e.wrap    = m_wrap;
        e.retired = m_retired;
        sb_q.push_back(e);
        p_reset = r; p_stall = s; p_lpc = l; p_tgt = t;
        @(negedge clk);
        rom_addr = bus.imem_addr;
    endtask

    task automatic step(input logic r, input logic s, input logic l, input logic [7:0] t);
        tick();
        drive(r, s, l, t);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                if (bus.pc !== e.pc || bus.imem_addr !== e.addr || bus.instr_valid !== e.valid ||
                    bus.opcode !== e.op || bus.literal !== e.lit || bus.halted !== e.halted ||
                    bus.pc_wrap !== e.wrap || bus.retired !== e.retired) begin
                    miscompares++;
                    $display("FAIL vec%0d: got pc=%h addr=%h v=%b op=%h lit=%h halt=%b wrap=%b ret=%0d, expected pc=%h addr=%h v=%b op=%h lit=%h halt=%b wrap=%b ret=%0d",
                             vectors, bus.pc, bus.imem_addr, bus.instr_valid, bus.opcode, bus.literal,
                             bus.halted, bus.pc_wrap, bus.retired, e.pc, e.addr, e.valid, e.op, e.lit,
                             e.halted, e.wrap, e.retired);
                end
            end
        end
    end

    initial begin
        int stall_cnt;
        reset = 1'b1; bus.stall = 1'b0; bus.L_PC = 1'b0; bus.pc_target = 8'h00;
        p_reset = 1'b1; p_stall = 1'b0; p_lpc = 1'b0; p_tgt = 8'h00; rom_addr = 8'h00;
        m_pc = 8'h00; m_valid = 1'b0; m_halted = 1'b0; m_wrap = 1'b0; m_retired = 16'd0;
        fill_mem(1'b0);
        mem[0] = 15'h0101; mem[1] = 15'h0202; mem[2] = 15'h0303; mem[3] = 15'h0404;
        cur_word = mem[0];
        bus.imem_rdata = mem[0];

        // sequential fetch
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

        // jump at pc 2 to 0x40
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_valid && m_pc == 8'h02) drive(1'b0, 1'b0, 1'b1, 8'h40);
            else drive(1'b0, 1'b0, 1'b0, 8'h00);
        end

        // stall at pc 5 with a pending jump, then release
        tick();
        mem[6] = {HALT_OP, 8'h10};
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        stall_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (m_valid && m_pc == 8'h05 && stall_cnt < 3) begin
                drive(1'b0, 1'b1, 1'b1, 8'h20);
                stall_cnt++;
            end else if (m_valid && m_pc == 8'h05) drive(1'b0, 1'b0, 1'b1, 8'h20);
            else drive(1'b0, 1'b0, 1'b0, 8'h00);
        end

        // halt beats a simultaneous jump; stall/jump ignored while halted
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_halted) drive(1'b0, ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0), 8'($urandom));
            else if (m_valid && m_pc == 8'h06) drive(1'b0, 1'b0, 1'b1, 8'h33);
            else drive(1'b0, 1'b0, 1'b0, 8'h00);
        end

        // halt after 20 retires, then one reset cycle while halted
        tick();
        fill_mem(1'b0);
        mem[19] = {HALT_OP, 8'h00};
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

        // sequential wrap through 0xFF
        tick();
        fill_mem(1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 264; i++) step(1'b0, 1'b0, 1'b0, 8'h00);

        // jump to 0 from 0x10 must not set the wrap flag
        step(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 24; i++) begin
            tick();
            if (m_valid && m_pc == 8'h10) drive(1'b0, 1'b0, 1'b1, 8'h00);
            else drive(1'b0, 1'b0, 1'b0, 8'h00);
        end

        // randomized traffic with occasional resets and halts
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 99) == 0) begin
                fill_mem(1'b1);
                drive(1'b1, ($urandom_range(0, 1) == 0), ($urandom_range(0, 1) == 0), 8'($urandom));
            end else begin
                drive(1'b0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0), 8'($urandom));
            end
        end

        @(posedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
